ajuste_multicampo: RTL



---
 rtl/ajuste_multicampo_pkg.sv | 41 ++++
 rtl/ajuste_multicampo_repetidor.sv | 63 ++++++
 rtl/ajuste_multicampo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ajuste_multicampo_pkg.sv
// ---------------------------------------------------------------------------
// ajuste_pkg
// Shared types and helpers for the multi-field time-adjust controller.
//   estado_t         : controller state (NORMAL / AJUSTE)
//   LIMITES_RELOGIO  : default wrap limits for a clock, packed field 2..0
//                      as {hours=23, minutes=59, seconds=59}
//   wrap_inc/wrap_dec: wrap-around step of a field value against its limit.
//                      They work on a wide unsigned word; callers truncate to
//                      the field width, which gives the natural W-bit rollover
//                      for values loaded above their limit.
// ---------------------------------------------------------------------------
package ajuste_pkg;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    AJUSTE = 1'b1
  } estado_t;

  localparam int W_RELOGIO = 6;
  localparam int N_RELOGIO = 3;
  localparam logic [N_RELOGIO*W_RELOGIO-1:0] LIMITES_RELOGIO = {6'd23, 6'd59, 6'd59};

  localparam int W_ARIT = 32;

  function automatic logic [W_ARIT-1:0] wrap_inc(input logic [W_ARIT-1:0] v,
                                                 input logic [W_ARIT-1:0] lim);
    if (v == lim) begin
      return '0;
    end
    return v + W_ARIT'(1);
  endfunction

  function automatic logic [W_ARIT-1:0] wrap_dec(input logic [W_ARIT-1:0] v,
                                                 input logic [W_ARIT-1:0] lim);
    if (v == '0) begin
      return lim;
    end
    return v - W_ARIT'(1);
  endfunction

endpackage

// File: rtl/ajuste_multicampo_repetidor.sv
// ---------------------------------------------------------------------------
// repetidor_botao
// Rising-edge detector with auto-repeat for one push button.
//   i_clk      : clock
//   i_rst      : asynchronous active-high reset
//   i_btn      : debounced, synchronous button level
//   i_bloqueio : inhibit (other direction also held): no step, repeat disarmed
//   o_borda    : rising edge of i_btn (raw, not inhibited)
//   o_passo    : one-cycle step pulse: on the edge, then REPEAT_DELAY cycles
//                after the edge, then every REPEAT_RATE cycles while held
// ---------------------------------------------------------------------------
module repetidor_botao #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  input  logic i_bloqueio,
  output logic o_borda,
  output logic o_passo
);

  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(MAX_CNT + 1);

  logic          r_prev;
  logic          r_rep;      // 1 once the first (delayed) repeat has fired
  logic [CW-1:0] r_cnt;      // cycles since the last step; 0 = repeat disarmed
  logic [CW-1:0] w_alvo;
  logic          w_vence;

  assign o_borda = i_btn & ~r_prev;
  assign w_alvo  = r_rep ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);
  assign w_vence = i_btn && (r_cnt != '0) && (r_cnt == w_alvo);
  assign o_passo = ~i_bloqueio & (o_borda | w_vence);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev <= 1'b0;
      r_rep  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= i_btn;
      if (!i_btn || i_bloqueio) begin
        // Released, or both directions held: disarm until the next edge.
        r_rep <= 1'b0;
        r_cnt <= '0;
      end else if (o_borda) begin
        r_rep <= 1'b0;
        r_cnt <= CW'(1);
      end else if (r_cnt != '0) begin
        if (w_vence) begin
          r_rep <= 1'b1;
          r_cnt <= CW'(1);
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ajuste_multicampo.sv
// ---------------------------------------------------------------------------
// ajuste_multicampo
// Multi-field time-adjust controller between debounced buttons and a clock
// counter. In NORMAL it mirrors the live counter; in AJUSTE it freezes a
// shadow copy, lets the user step the selected field, and either commits it
// (load strobe) or abandons it (cancel / inactivity timeout).
//   clk_100MHz  : clock
//   rst         : asynchronous active-high reset
//   btn_mode    : enter adjust / next field / commit after the last field
//   btn_inc     : increment selected field (auto-repeat while held)
//   btn_dec     : decrement selected field (auto-repeat while held)
//   btn_cancel  : leave adjust without load
//   valores_in  : live counter values, field i at [i*W +: W]
//   pause       : high while adjusting
//   load        : one-cycle commit strobe
//   modo_ajuste : 0 = normal, i+1 = field i selected
//   blink       : display enable for the selected field
//   valores_out : values to display / load
// ---------------------------------------------------------------------------
module ajuste_multicampo
  import ajuste_pkg::*;
#(
  parameter int                    N_CAMPOS     = 3,
  parameter int                    W            = 6,
  parameter logic [N_CAMPOS*W-1:0] LIMITES      = LIMITES_RELOGIO,
  parameter int                    REPEAT_DELAY = 50_000_000,
  parameter int                    REPEAT_RATE  = 10_000_000,
  parameter int                    TIMEOUT_CYC  = 1_000_000_000,
  parameter int                    BLINK_CYC    = 25_000_000
) (
  input  logic                             clk_100MHz,
  input  logic                             rst,
  input  logic                             btn_mode,
  input  logic                             btn_inc,
  input  logic                             btn_dec,
  input  logic                             btn_cancel,
  input  logic [N_CAMPOS*W-1:0]            valores_in,
  output logic                             pause,
  output logic                             load,
  output logic [$clog2(N_CAMPOS+1)-1:0]    modo_ajuste,
  output logic                             blink,
  output logic [N_CAMPOS*W-1:0]            valores_out
);

  localparam int WM = $clog2(N_CAMPOS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_CYC + 1);

  estado_t               r_estado;
  logic [WM-1:0]         r_campo;
  logic                  r_load;
  logic [N_CAMPOS*W-1:0] r_valores;
  logic                  r_prev_mode;
  logic                  r_prev_cancel;
  logic [TW-1:0]         r_timeout;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink;

  logic                  w_borda_mode;
  logic                  w_borda_cancel;
  logic                  w_borda_inc;
  logic                  w_borda_dec;
  logic                  w_passo_inc;
  logic                  w_passo_dec;
  logic                  w_ambos;
  logic                  w_passo_aplicado;
  logic                  w_atividade;
  logic                  w_ultimo;
  logic [N_CAMPOS*W-1:0] w_valores_passo;

  assign w_borda_mode   = btn_mode & ~r_prev_mode;
  assign w_borda_cancel = btn_cancel & ~r_prev_cancel;
  assign w_ambos        = btn_inc & btn_dec;

  repetidor_botao #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_inc (
    .i_clk      (clk_100MHz),
    .i_rst      (rst),
    .i_btn      (btn_inc),
    .i_bloqueio (w_ambos),
    .o_borda    (w_borda_inc),
    .o_passo    (w_passo_inc)
  );

  repetidor_botao #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_dec (
    .i_clk      (clk_100MHz),
    .i_rst      (rst),
    .i_btn      (btn_dec),
    .i_bloqueio (w_ambos),
    .o_borda    (w_borda_dec),
    .o_passo    (w_passo_dec)
  );

  // A step coinciding with a mode or cancel edge is dropped.
  assign w_passo_aplicado = (r_estado == AJUSTE) && (w_passo_inc || w_passo_dec) &&
                            !w_borda_mode && !w_borda_cancel;

  assign w_atividade = w_borda_mode | w_borda_cancel | w_borda_inc | w_borda_dec |
                       w_passo_inc | w_passo_dec;

  assign w_ultimo = (r_campo == WM'(N_CAMPOS - 1));

  // Next shadow value per field: only the selected field moves on a step.
  genvar gi;
  generate
    for (gi = 0; gi < N_CAMPOS; gi++) begin : g_campo
      logic [W-1:0] w_atual;
      logic [W-1:0] w_lim;
      logic [W-1:0] w_mais;
      logic [W-1:0] w_menos;
      logic         w_sel;

      assign w_atual = r_valores[gi*W +: W];
      assign w_lim   = LIMITES[gi*W +: W];
      assign w_mais  = W'(wrap_inc(W_ARIT'(w_atual), W_ARIT'(w_lim)));
      assign w_menos = W'(wrap_dec(W_ARIT'(w_atual), W_ARIT'(w_lim)));
      assign w_sel   = w_passo_aplicado && (r_campo == WM'(gi));

      assign w_valores_passo[gi*W +: W] = !w_sel      ? w_atual :
                                          w_passo_inc ? w_mais  : w_menos;
    end
  endgenerate

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_estado      <= NORMAL;
      r_campo       <= '0;
      r_load        <= 1'b0;
      r_valores     <= '0;
      r_prev_mode   <= 1'b0;
      r_prev_cancel <= 1'b0;
      r_timeout     <= '0;
      r_blink_cnt   <= '0;
      r_blink       <= 1'b1;
    end else begin
      r_prev_mode   <= btn_mode;
      r_prev_cancel <= btn_cancel;
      r_load        <= 1'b0;

      case (r_estado)
        AJUSTE: begin
          r_valores <= w_valores_passo;

          if (w_borda_cancel) begin
            r_estado <= NORMAL;
            r_campo  <= '0;
          end else if (w_borda_mode) begin
            if (w_ultimo) begin
              // Commit: load rises next cycle while valores_out still holds
              // the adjusted values (NORMAL reloads them one cycle later).
              r_estado <= NORMAL;
              r_campo  <= '0;
              r_load   <= 1'b1;
            end else begin
              r_campo <= r_campo + WM'(1);
            end
          end else if (!w_atividade && (r_timeout == TW'(TIMEOUT_CYC - 1))) begin
            r_estado <= NORMAL;
            r_campo  <= '0;
          end

          r_timeout <= w_atividade ? '0 : r_timeout + TW'(1);

          if (w_passo_aplicado || w_borda_mode) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
          end else if (r_blink_cnt == BW'(BLINK_CYC - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
          end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
          end
        end

        default: begin
          // NORMAL: mirror the live counter; the capture made on the entry
          // edge becomes the shadow copy for AJUSTE.
          r_valores   <= valores_in;
          r_campo     <= '0;
          r_timeout   <= '0;
          r_blink_cnt <= '0;
          r_blink     <= 1'b1;
          if (w_borda_mode) begin
            r_estado <= AJUSTE;
          end
        end
      endcase
    end
  end

  assign pause       = (r_estado == AJUSTE);
  assign load        = r_load;
  assign modo_ajuste = (r_estado == AJUSTE) ? (r_campo + WM'(1)) : '0;
  assign blink       = (r_estado == NORMAL) | r_blink;
  assign valores_out = r_valores;

endmodule
